// File: rtl/vga_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : vga_fifo_reader
// Description : Read-side controller for the pixel line FIFO. Generates VGA
//               raster timing, issues one FIFO read per active pixel while
//               streaming, and registers the FIFO word onto the RGB pins in
//               step with hsync/vsync/de. Handles frame-aligned start/stop and
//               underrun substitution.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               pix_ce          - pixel clock enable (counters/pipeline step)
//               en              - streaming enable
//               fifo_empty      - FIFO empty flag
//               fifo_data       - FIFO registered data_out
//               fifo_rd         - FIFO read strobe (combinational)
//               rgb             - registered pixel
//               hsync, vsync    - active-low syncs, aligned with rgb
//               de              - registered active-video flag
//               frame_start     - one-clk pulse at start of each RUN frame
//               underrun        - sticky underrun flag, cleared on RUN entry
//               busy            - high while streaming (RUN)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fifo_reader #(
  parameter int                DATA_W         = 12,
  parameter int                H_ACTIVE       = 640,
  parameter int                H_FP           = 16,
  parameter int                H_SYNC         = 96,
  parameter int                H_BP           = 48,
  parameter int                V_ACTIVE       = 480,
  parameter int                V_FP           = 10,
  parameter int                V_SYNC         = 2,
  parameter int                V_BP           = 33,
  parameter logic [DATA_W-1:0] UNDERRUN_COLOR = 12'hF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start,
  output logic              underrun,
  output logic              busy
);

  // --------------------------------------------------------------------------
  // Raster constants, all sized to the 10-bit counters
  // --------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_RUN        = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [9:0]        hcnt_q, hcnt_d;
  logic [9:0]        vcnt_q, vcnt_d;
  logic              underrun_q, underrun_d;
  logic              frame_start_q, frame_start_d;

  // Stage 1: attributes of the pixel at the counter position
  logic              de1_q, de1_d;
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;
  logic              rd1_q, rd1_d;
  logic              ur1_q, ur1_d;

  // Stage 2: output pins
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic              de_q, de_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;

  // --------------------------------------------------------------------------
  // Raster decode
  // --------------------------------------------------------------------------
  logic h_last;
  logic v_last;
  logic frame_wrap;
  logic active;
  logic hsync_raw;
  logic vsync_raw;
  logic pix_slot;
  logic pix_read;
  logic pix_underrun;

  assign h_last     = (hcnt_q == H_LAST);
  assign v_last     = (vcnt_q == V_LAST);
  assign frame_wrap = pix_ce && h_last && v_last;
  assign active     = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
  assign hsync_raw  = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
  assign vsync_raw  = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));

  // An active pixel while streaming either reads the FIFO or underruns.
  assign pix_slot     = pix_ce && active && (state_q == ST_RUN);
  assign pix_read     = pix_slot && !fifo_empty;
  assign pix_underrun = pix_slot && fifo_empty;

  // Gated by rst so no strobe can escape while the async reset is asserted.
  assign fifo_rd = pix_read && !rst;

  // --------------------------------------------------------------------------
  // Free-running raster counters
  // --------------------------------------------------------------------------
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_ce) begin
      if (h_last) begin
        hcnt_d = 10'd0;
        vcnt_d = v_last ? 10'd0 : (vcnt_q + 10'd1);
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Streaming state machine; start and stop only happen at a frame wrap so
  // the sink always sees whole frames.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    frame_start_d = 1'b0;
    underrun_d    = underrun_q || pix_underrun;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (frame_wrap && !fifo_empty) begin
          state_d       = ST_RUN;
          underrun_d    = 1'b0;
          frame_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        // en is only honoured at the wrap, so a mid-frame drop finishes
        // the frame in progress.
        if (frame_wrap) begin
          if (!en) begin
            state_d = ST_IDLE;
          end else begin
            frame_start_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output pipeline. The FIFO presents the word on the edge that samples the
  // read, so stage 2 picks it up on the following pixel edge, keeping data
  // and syncs at the same two-tick latency.
  // --------------------------------------------------------------------------
  always_comb begin
    de1_d   = de1_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    rd1_d   = rd1_q;
    ur1_d   = ur1_q;
    rgb_d   = rgb_q;
    de_d    = de_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_ce) begin
      de1_d   = active;
      hs1_d   = hsync_raw;
      vs1_d   = vsync_raw;
      rd1_d   = pix_read;
      ur1_d   = pix_underrun;
      de_d    = de1_q;
      hsync_d = hs1_q;
      vsync_d = vs1_q;
      if (rd1_q) begin
        rgb_d = fifo_data;
      end else if (ur1_q) begin
        rgb_d = UNDERRUN_COLOR;
      end else begin
        rgb_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      underrun_q    <= 1'b0;
      frame_start_q <= 1'b0;
      de1_q         <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      rd1_q         <= 1'b0;
      ur1_q         <= 1'b0;
      rgb_q         <= '0;
      de_q          <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      underrun_q    <= underrun_d;
      frame_start_q <= frame_start_d;
      de1_q         <= de1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      rd1_q         <= rd1_d;
      ur1_q         <= ur1_d;
      rgb_q         <= rgb_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign rgb         = rgb_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign busy        = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_vga_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fifo_reader
// Description : Self-checking bench for vga_fifo_reader using a reduced
//               raster (15x8) so whole frames run quickly. The bench plays
//               the FIFO and writer, and keeps a frame-level reference model
//               that predicts every output on every clk.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fifo_reader;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [11:0] UC = 12'hF00;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic        en;
  logic        fifo_empty;
  logic [11:0] fifo_data;
  logic        fifo_rd;
  logic [11:0] rgb;
  logic        hsync, vsync, de, frame_start, underrun, busy;

  vga_fifo_reader #(
    .DATA_W(12), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .UNDERRUN_COLOR(UC)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } rec_t;

  localparam rec_t BLANK = '{rgb: 12'h000, de: 1'b0, hs: 1'b1, vs: 1'b1};

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO / writer model
  logic [11:0] fq[$];
  logic [11:0] next_word;
  bit          refill, starve, force_empty;

  // Reference model state
  int   m_pos;
  bit   m_run, m_armed, m_ur, m_fs;
  rec_t pipe[$];
  rec_t out_exp;

  int rd_count, fs_count, tick_cnt, first_hs_tick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_run = 0; m_armed = 0; m_ur = 0; m_fs = 0;
    pipe.delete();
    pipe.push_back(BLANK);
    out_exp = BLANK;
    tick_cnt = 0;
    first_hs_tick = -1;
  endtask

  // One clk of stimulus, prediction and checking.
  task automatic step(input bit pce);
    int   h, v;
    bit   act, emp, rd_exp, rd_seen, wrap;
    rec_t rec;
    @(negedge clk);
    pix_ce = pce;
    if (refill) begin
      while (fq.size() < 6) begin
        fq.push_back(next_word);
        next_word = next_word + 12'd1;
      end
    end
    fifo_empty = (fq.size() == 0) || starve || force_empty;
    #1;
    h    = m_pos % HT;
    v    = m_pos / HT;
    act  = (h < HA) && (v < VA);
    emp  = fifo_empty;
    wrap = pce && (m_pos == FT - 1);
    rd_exp  = pce && act && m_run && !emp;
    rd_seen = fifo_rd;
    check("fifo_rd", rd_seen, rd_exp);
    m_fs = 0;
    if (pce) begin
      rec.de  = act;
      rec.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
      rec.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
      rec.rgb = (act && m_run) ? (emp ? UC : fq[0]) : 12'h000;
      pipe.push_back(rec);
      out_exp = pipe.pop_front();
      if (act && m_run && emp) m_ur = 1;
      m_pos = (m_pos + 1) % FT;
    end
    // Frame-level streaming rules
    if (m_run) begin
      if (wrap) begin
        if (!en) begin m_run = 0; m_armed = 0; end
        else m_fs = 1;
      end
    end else if (m_armed) begin
      if (!en) m_armed = 0;
      else if (wrap && !emp) begin m_run = 1; m_ur = 0; m_fs = 1; end
    end else if (en) begin
      m_armed = 1;
    end
    @(posedge clk);
    #1;
    if (rd_seen && fq.size() > 0) fifo_data = fq.pop_front();
    if (pce) tick_cnt++;
    if (rd_seen) rd_count++;
    if (frame_start === 1'b1) fs_count++;
    if (first_hs_tick < 0 && hsync === 1'b0) first_hs_tick = tick_cnt;
    check("rgb", rgb, out_exp.rgb);
    check("de", de, out_exp.de);
    check("hsync", hsync, out_exp.hs);
    check("vsync", vsync, out_exp.vs);
    check("underrun", underrun, m_ur);
    check("busy", busy, m_run);
    check("frame_start", frame_start, m_fs);
  endtask

  task automatic run_ticks(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        step(1'b0); step(1'b0); step(1'b0);
      end
      step(1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; pix_ce = 1'b0; en = 1'b0; fifo_empty = 1'b1; fifo_data = 12'h000;
    refill = 0; starve = 0; force_empty = 0; next_word = 12'h001;
    rd_count = 0; fs_count = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", rgb, 12'h000);
    check("rst_de", de, 1'b0);
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_fifo_rd", fifo_rd, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // Partial line, then asynchronous reset while hsync is low
    run_ticks(13, 1'b0);
    check("pre_rst_hsync_low", hsync, 1'b0);
    @(negedge clk);
    pix_ce = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_hsync", hsync, 1'b1);
    check("async_rst_vsync", vsync, 1'b1);
    check("async_rst_de", de, 1'b0);
    check("async_rst_rgb", rgb, 12'h000);
    check("async_rst_fifo_rd", fifo_rd, 1'b0);
    @(posedge clk);
    #1;
    pix_ce = 1'b0;
    rst = 1'b0;
    model_reset();

    // Enable with a filled FIFO: one waiting frame, then RUN
    refill = 1;
    en = 1'b1;
    fs_count = 0;
    run_ticks(FT, 1'b0);
    check("first_hsync_tick", first_hs_tick, HA + HF + 2);
    check("run_entered", busy, 1'b1);
    check("entry_frame_start", fs_count, 1);

    // Full frame of the incrementing pattern
    rd_count = 0;
    run_ticks(2, 1'b0);
    check("first_pixel_rgb", rgb, 12'h001);
    check("first_pixel_de", de, 1'b1);
    run_ticks(FT - 2, 1'b0);
    check("frame_reads", rd_count, HA * VA);
    check("no_underrun", underrun, 1'b0);

    // Underrun on pixel (3,0) only
    rd_count = 0;
    run_ticks(3, 1'b0);
    force_empty = 1;
    step(1'b1);
    force_empty = 0;
    run_ticks(FT - 4, 1'b0);
    check("underrun_reads", rd_count, HA * VA - 1);
    check("underrun_sticky", underrun, 1'b1);

    // pix_ce one clk in four
    rd_count = 0;
    run_ticks(FT, 1'b1);
    check("gap_reads", rd_count, HA * VA);
    check("gap_underrun_kept", underrun, 1'b1);

    // en drop mid-frame at (4,2)
    rd_count = 0;
    run_ticks(2 * HT + 4, 1'b0);
    en = 1'b0;
    run_ticks(FT - (2 * HT + 4), 1'b0);
    check("drop_frame_reads", rd_count, HA * VA);
    check("drop_busy", busy, 1'b0);
    rd_count = 0;
    run_ticks(FT, 1'b0);
    check("idle_frame_reads", rd_count, 0);

    // Start gating on an empty FIFO at the wrap
    starve = 1;
    en = 1'b1;
    run_ticks(FT, 1'b0);
    check("gated_busy", busy, 1'b0);
    starve = 0;
    fs_count = 0;
    run_ticks(FT, 1'b0);
    check("restart_busy", busy, 1'b1);
    check("restart_frame_start", fs_count, 1);
    check("restart_underrun_cleared", underrun, 1'b0);
    run_ticks(4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_fifo_reader.md
# vga_fifo_reader

Read-side controller for the 12-bit pixel line FIFO. It generates 640x480 VGA raster timing and issues one FIFO read strobe per active pixel. It registers the FIFO output onto the RGB pins, aligned with hsync, vsync and de. It sits between the pixel FIFO (a registered `data_out`, updated on the clk edge where read is sampled high) and the DAC/VGA connector. Frame sequencing and underrun detection are handled here, so the write side only has to keep the FIFO non-empty.

## Interface
- DATA_W, 12, pixel width (RGB 4:4:4)
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48 — horizontal pixels; H_TOTAL = 800
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33 — vertical lines; V_TOTAL = 525
- UNDERRUN_COLOR, 12'hF00, value driven on rgb for an active pixel with no FIFO data
- clk, input, 1, system clock; all logic is on the rising edge
- rst, input, 1, asynchronous, active-high reset
- pix_ce, input, 1, pixel clock enable; counters and output pipeline advance only when high
- en, input, 1, streaming enable
- fifo_empty, input, 1, FIFO empty flag
- fifo_data, input, DATA_W, FIFO data_out
- fifo_rd, output, 1, FIFO read strobe
- rgb, output, DATA_W, registered pixel
- hsync, output, 1, active-low horizontal sync
- vsync, output, 1, active-low vertical sync
- de, output, 1, registered active-video flag
- frame_start, output, 1, one-clk pulse at the start of each RUN frame
- underrun, output, 1, sticky flag; cleared on entry to RUN
- busy, output, 1, high while state is RUN

## Operation
- Counters hcnt (10b, 0..H_TOTAL-1) and vcnt (10b, 0..V_TOTAL-1) free-run in every state, advancing on pix_ce.
  - hcnt wraps to 0 at 799, and vcnt increments on that wrap.
  - vcnt wraps to 0 when hcnt=799 and vcnt=524 (the "frame wrap").
- active = (hcnt < 640) && (vcnt < 480).
- Sync windows (raw, before the output pipeline):
  - hsync_raw is low for hcnt 656..751.
  - vsync_raw is low for vcnt 490..491.
- States:
  - IDLE: no reads. en=1 → WAIT_FRAME.
  - WAIT_FRAME: no reads. en=0 → IDLE. At a frame wrap with en=1 and !fifo_empty → RUN, with underrun cleared and frame_start pulsed.
  - RUN: reads enabled. At a frame wrap: if en=0 → IDLE, otherwise stay in RUN and pulse frame_start. Deasserting en mid-frame completes the current frame.
- fifo_rd = pix_ce && active && state==RUN && !fifo_empty && !rst. This signal is combinational, at most one clk per pixel, and never issued when fifo_empty=1.
- Underrun: an active pixel in RUN with fifo_empty=1 sets the underrun flag, issues no read, and outputs UNDERRUN_COLOR for that pixel. Streaming continues with the next pixel.
- Outside RUN, active pixels output 12'h000 with de=1. Blanking pixels output rgb=0, de=0.

## Timing
- Two-stage pipeline, each stage clocked on a pix_ce edge.
  - Stage 1, edge E0 at counter position p: the FIFO read is issued, and de/hsync/vsync/underrun-select/run-select for p are captured into d1 registers.
  - Stage 2, next pix_ce edge E1: rgb, de, hsync and vsync are loaded from d1.
  - rgb = fifo_data if the pixel was read, UNDERRUN_COLOR if it underran, 0 otherwise.
- Output latency is 2 pix_ce ticks after the counter position for all four outputs. Sync and data are therefore mutually aligned.
- Gaps in pix_ce freeze everything: fifo_data is held because no read occurs, and outputs are held.
- frame_start asserts on the clk following the frame-wrap edge, for one clk regardless of pix_ce.
- Reset values:
  - rgb=0, de=0, hsync=1, vsync=1, fifo_rd=0, underrun=0, frame_start=0, busy=0
  - hcnt=0, vcnt=0, state=IDLE, d1 registers cleared to the blank/inactive-sync values
- Reset mid-frame takes effect immediately (asynchronous). After release, counters restart at (0,0) and no read is issued until a full WAIT_FRAME→RUN transition.
- Simultaneous en fall and frame wrap in RUN → IDLE. No reads in the next frame.

## Test plan
- Reset: assert rst mid-line with pix_ce=1 → all outputs at their reset values within the same clk. After release, the first hsync low occurs at pix_ce tick 656+2.
- Full frame: prefill the FIFO with an incrementing pattern 12'h001.., keep it non-empty, en=1.
  - Expect exactly 307200 fifo_rd pulses per frame.
  - First de=1 two ticks after (0,0), with rgb=12'h001. The rgb sequence matches the pattern, and underrun stays 0.
- Underrun: force fifo_empty=1 for pixel (100,0) only.
  - No fifo_rd for that pixel.
  - rgb=12'hF00 at that slot; pixel 101 carries the next FIFO word.
  - underrun=1 sticky until the next RUN entry.
- pix_ce gaps: pix_ce high 1-of-4 clks.
  - fifo_rd pulse width is exactly 1 clk.
  - Output sequence is identical to the full-frame scenario.
- en drop mid-frame at (320,240) → reads continue to the end of the frame. busy falls at the frame wrap, and zero reads occur in the following frame.
- Start gating: en=1 with fifo_empty=1 at the frame wrap → remains in WAIT_FRAME. Fill the FIFO → RUN entered at the next wrap, with one frame_start pulse.
